budget_arbiter: RTL

Budget-regulated round-robin arbiter that sequences the per-requester queues of the non-AXI domain into the shared serializer. Each queue gets a transaction budget that is reloaded at the start of every replenishment period. The arbiter grants non-empty queues that still hold budget, in round-robin order. It drives the selector index, the serializer activate signal and the per-queue pop pulses, so it is an alternative to the TDMA/EDF scheduler for bandwidth-regulated operation.

---
 rtl/budget_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/budget_arbiter.sv
// Budget-regulated round-robin arbiter: grants non-empty queues that still hold
// transaction budget for the current replenishment period, and drives the serializer handshake.
module budget_arbiter #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int REGISTER_SIZE    = 32,
    localparam int IW = $clog2(NUMBER_OF_QUEUES)
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic [NUMBER_OF_QUEUES-1:0]                      empty,
    input  logic [NUMBER_OF_QUEUES-1:0]                      full,
    input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   budgets,
    input  logic [REGISTER_SIZE-1:0]                         period,
    input  logic                                             consumed,
    output logic [IW-1:0]                                    id,
    output logic                                             enable,
    output logic [NUMBER_OF_QUEUES-1:0]                      hasBeenConsumed,
    output logic [NUMBER_OF_QUEUES-1:0]                      exhausted
);
    localparam int N = NUMBER_OF_QUEUES;
    localparam int R = REGISTER_SIZE;

    typedef enum logic [1:0] {IDLE, GRANT, POP} state_t;

    state_t              state, state_nxt;
    logic [N-1:0][R-1:0] remaining, remaining_nxt;
    logic [N-1:0]        exhausted_nxt;
    logic [R-1:0]        cnt;
    logic [IW-1:0]       last, pick;
    logic [N-1:0]        elig;
    logic                found;
    logic                reload;
    logic                regulated;

    assign regulated = (period != '0);
    assign reload    = regulated && (cnt >= period - 1'b1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (!regulated || reload)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // A full queue bypasses the budget so the domain can never deadlock.
    always_comb begin
        for (int i = 0; i < N; i++)
            elig[i] = ~empty[i] & (~regulated | (remaining[i] != '0) | full[i]);
    end

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = int'(last) + k;
            if (j >= N) j = j - N;
            if (!found && elig[j]) begin
                found = 1'b1;
                pick  = IW'(j);
            end
        end
    end

    // Reload takes priority over the pop decrement in the same cycle.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            remaining_nxt[i] = remaining[i];
            if (reload)
                remaining_nxt[i] = budgets[i];
            else if (state == POP && id == IW'(i) && remaining[i] != '0)
                remaining_nxt[i] = remaining[i] - 1'b1;
            exhausted_nxt[i] = (remaining_nxt[i] == '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            exhausted <= '0;
        end else begin
            remaining <= remaining_nxt;
            exhausted <= exhausted_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = GRANT;
            GRANT:   if (consumed) state_nxt = POP;
            POP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            id    <= '0;
            last  <= IW'(N - 1);
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                id   <= pick;
                last <= pick;
            end
        end
    end

    // Decoded from state so an asynchronous reset drops them at once.
    always_comb begin
        enable          = (state == GRANT);
        hasBeenConsumed = '0;
        if (state == POP)
            hasBeenConsumed[id] = 1'b1;
    end
endmodule
